fetch_redirect: RTL and testbench

//  IF stage and PC owner: drives the PC into instruction memory and delivers the IF/ID latch.

---
 rtl/fetch_redirect_pkg.sv | 34 +++
 rtl/fetch_hold_buf.sv | 43 ++++
 rtl/fetch_redirect.sv | 184 ++++++++++++++++++
 tb/tb_fetch_redirect.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_pkg.sv
// Shared definitions for the fetch/redirect stage: FSM state codes, the
// HALT opcode, the default bubble instruction, the hold-buffer slot type
// and the 16-bit carry-lookahead adder used as the PC incrementer.
package fetch_redirect_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [4:0]  OP_HALT           = 5'b00000;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;

    // One fetched instruction together with the PC+2 of its fetch address.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } fetch_slot_t;

    // 16-bit generate/propagate adder; the carry out is dropped so the sum wraps.
    function automatic logic [15:0] cla_16bit(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [16:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c[15:0];
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that parks a captured instruction while decode is
// stalled. clear (redirect) wins over load, load wins over drain.
module fetch_hold_buf
    import fetch_redirect_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic        drain_i,
    input  fetch_slot_t slot_i,
    output logic        valid_o,
    output fetch_slot_t slot_o
);

    logic        valid_q;
    fetch_slot_t slot_q;

    // Occupancy flag: the only state that must be known after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload capture.
    // NOTE: the payload has no reset; valid_q qualifies it, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (load_i) begin
            slot_q <= slot_i;
        end
    end

    assign valid_o = valid_q;
    assign slot_o  = slot_q;

endmodule

// File: rtl/fetch_redirect.sv
// IF stage / PC owner. Issues instruction-memory requests, tolerates
// variable memory latency and decode stalls, applies EX redirects (killing
// wrong-path fetches) and stops at HALT.
// Optional feature macro: FETCH_ALIGN_ERR_EN (odd redirect targets raise a
// sticky align_err and halt the fetch; otherwise bit 0 is cleared on load).
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] next_pc,
    input  logic        stall,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    output logic [15:0] IFID_Instr,
    output logic [15:0] IFID_PcPlusTwo,
    output logic        IFID_Valid,
    output logic        halted,
    output logic        align_err
);

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] tgt_q, tgt_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic        bad_q, bad_d;

    logic        req;
    logic        fire;
    logic        misaligned;
    logic [15:0] redirect_pc;
    logic [15:0] pc_plus_two;
    logic        hold_valid;
    logic        hold_load;
    logic        hold_drain;
    fetch_slot_t hold_slot;
    fetch_slot_t cap_slot;

    assign pc_plus_two = cla_16bit(pc_q, 16'd2);
    assign cap_slot    = {imem_data, pc_plus_two};

`ifdef FETCH_ALIGN_ERR_EN
    logic align_q;

    assign misaligned  = next_pc[0];
    assign redirect_pc = next_pc;
    assign align_err   = align_q;

    // Sticky record of any redirect to an odd address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_q <= 1'b0;
        end else if (flush && misaligned) begin
            align_q <= 1'b1;
        end
    end
`else
    assign misaligned  = 1'b0;
    assign redirect_pc = next_pc & 16'hFFFE;
    assign align_err   = 1'b0;
`endif

    // Request is live in RUN only when decode can take data and the skid slot is free.
    always_comb begin
        req = 1'b0;
        case (state_q)
            ST_RUN:   req = ~stall & ~hold_valid;
            ST_WAIT:  req = 1'b1;
            ST_DRAIN: req = 1'b1;
            default:  req = 1'b0;
        endcase
    end

    assign fire      = req & imem_done;
    assign imem_en   = req & ~rst;
    // During DRAIN pc_q still holds the abandoned address; the target waits in tgt_q.
    assign imem_addr = pc_q;

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (hold_load),
        .drain_i (hold_drain),
        .slot_i  (cap_slot),
        .valid_o (hold_valid),
        .slot_o  (hold_slot)
    );

    // Next-state: redirect first, otherwise skid drain plus per-state fetch progress.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        instr_d    = instr_q;
        pc2_d      = pc2_q;
        valid_d    = valid_q;
        bad_d      = bad_q;
        hold_load  = 1'b0;
        hold_drain = 1'b0;

        if (flush) begin
            instr_d = NOP_INSTR;
            pc2_d   = 16'h0000;
            valid_d = 1'b0;
            bad_d   = misaligned;
            if (req && !imem_done) begin
                tgt_d   = redirect_pc;
                state_d = ST_DRAIN;
            end else begin
                pc_d    = redirect_pc;
                state_d = misaligned ? ST_HALTED : ST_RUN;
            end
        end else begin
            if (hold_valid && !stall) begin
                instr_d    = hold_slot.instr;
                pc2_d      = hold_slot.pc2;
                valid_d    = 1'b1;
                hold_drain = 1'b1;
            end
            case (state_q)
                ST_RUN, ST_WAIT: begin
                    if (fire) begin
                        pc_d = pc_plus_two;
                        if (stall) begin
                            hold_load = 1'b1;
                        end else begin
                            instr_d = imem_data;
                            pc2_d   = pc_plus_two;
                            valid_d = 1'b1;
                        end
                        state_d = (imem_data[15:11] == OP_HALT) ? ST_HALTED : ST_RUN;
                    end else if (req) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (imem_done) begin
                        pc_d    = tgt_q;
                        state_d = bad_q ? ST_HALTED : ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and IF/ID registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
        end
    end

    assign IFID_Instr     = instr_q;
    assign IFID_PcPlusTwo = pc2_q;
    assign IFID_Valid     = valid_q;
    assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed plus random bench for fetch_redirect. A transaction-level model
// (PC, outstanding-request flag, wrong-path flag, skid queue) predicts the
// memory request and the IF/ID contents every cycle.
module tb_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] next_pc;
    logic        stall;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic [15:0] IFID_Instr;
    logic [15:0] IFID_PcPlusTwo;
    logic        IFID_Valid;
    logic        halted;
    logic        align_err;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
    } ent_t;

    logic [15:0] m_pc, m_req_addr, m_instr, m_pc2;
    logic        m_valid, m_busy, m_discard, m_halted;
    ent_t        m_hold[$];

    always #5 clk = ~clk;

    fetch_redirect dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .next_pc        (next_pc),
        .stall          (stall),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_done      (imem_done),
        .imem_data      (imem_data),
        .IFID_Instr     (IFID_Instr),
        .IFID_PcPlusTwo (IFID_PcPlusTwo),
        .IFID_Valid     (IFID_Valid),
        .halted         (halted),
        .align_err      (align_err)
    );

    // Program image: non-HALT opcodes for every address below 0x0800.
    function automatic logic [15:0] prog(input logic [15:0] a);
        return 16'h1000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 16'h0000;
        m_req_addr = 16'h0000;
        m_instr   = 16'h0800;
        m_pc2     = 16'h0000;
        m_valid   = 1'b0;
        m_busy    = 1'b0;
        m_discard = 1'b0;
        m_halted  = 1'b0;
        m_hold.delete();
    endtask

    task automatic chk_regs(input string pfx);
        chk({pfx, "_instr"}, IFID_Instr, m_instr);
        chk({pfx, "_pc2"}, IFID_PcPlusTwo, m_pc2);
        chk({pfx, "_valid"}, {15'd0, IFID_Valid}, {15'd0, m_valid});
        chk({pfx, "_halted"}, {15'd0, halted}, {15'd0, m_halted});
        chk({pfx, "_align_err"}, {15'd0, align_err}, 16'd0);
    endtask

    // One clock: drive inputs at negedge, check, advance the model, return at posedge+1.
    task automatic cyc(input logic s, input logic f, input logic [15:0] npc,
                       input logic d, input logic use_dat, input logic [15:0] dat);
        logic        e;
        logic [15:0] a;
        logic [15:0] drv;
        logic [15:0] p2;
        ent_t        ent;
        @(negedge clk);
        a   = m_busy ? m_req_addr : m_pc;
        drv = use_dat ? dat : prog(a);
        stall = s; flush = f; next_pc = npc; imem_done = d; imem_data = drv;
        #1;
        e = m_busy || (!m_halted && !s && m_hold.size() == 0);
        chk("imem_en", {15'd0, imem_en}, {15'd0, e});
        if (e) chk("imem_addr", imem_addr, a);
        chk_regs("cyc");
        if (f) begin
            m_pc = npc & 16'hFFFE;
            m_instr = 16'h0800; m_pc2 = 16'h0000; m_valid = 1'b0;
            m_hold.delete();
            m_halted = 1'b0;
            if (e && !d) begin
                m_busy = 1'b1; m_discard = 1'b1; m_req_addr = a;
            end else begin
                m_busy = 1'b0; m_discard = 1'b0;
            end
        end else begin
            if (m_hold.size() > 0 && !s) begin
                ent = m_hold.pop_front();
                m_instr = ent.instr; m_pc2 = ent.pc2; m_valid = 1'b1;
            end
            if (e && d) begin
                m_busy = 1'b0;
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    p2 = a + 16'd2;
                    m_pc = p2;
                    if (s) begin
                        ent.instr = drv; ent.pc2 = p2;
                        m_hold.push_back(ent);
                    end else begin
                        m_instr = drv; m_pc2 = p2; m_valid = 1'b1;
                    end
                    if (drv[15:11] == 5'b00000) m_halted = 1'b1;
                end
            end else if (e) begin
                m_busy = 1'b1; m_req_addr = a;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; next_pc = 16'h0000; stall = 1'b0;
        imem_done = 1'b0; imem_data = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_imem_en", {15'd0, imem_en}, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk_regs("rst");
        rst = 1'b0;

        // Zero-wait memory from address 0: one instruction per cycle.
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t1_pc2_a", IFID_PcPlusTwo, 16'h0002);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t1_pc2_b", IFID_PcPlusTwo, 16'h0004);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t1_pc2_c", IFID_PcPlusTwo, 16'h0006);
        chk("t1_valid", {15'd0, IFID_Valid}, 16'd1);

        // Three-cycle latency on 0x0004.
        cyc(1, 1, 16'h0004, 0, 0, 16'h0);
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        chk("t2_addr_w1", imem_addr, 16'h0004);
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        chk("t2_addr_w2", imem_addr, 16'h0004);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t2_capture", IFID_Instr, 16'h1004);
        chk("t2_next_addr", imem_addr, 16'h0006);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);

        // Redirect to 0x0040 while waiting on 0x0008.
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        cyc(0, 1, 16'h0040, 0, 0, 16'h0);
        chk("t3_drain_addr", imem_addr, 16'h0008);
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 1, 16'hBEEF);
        chk("t3_no_capture", IFID_Instr, 16'h0800);
        chk("t3_redirect_addr", imem_addr, 16'h0040);

        // Stall across a completing fetch of 0xC123.
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        cyc(1, 0, 16'h0, 1, 1, 16'hC123);
        chk("t4_held_a", {15'd0, IFID_Valid}, 16'd0);
        cyc(1, 0, 16'h0, 0, 0, 16'h0);
        chk("t4_held_b", IFID_Instr, 16'h0800);
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        chk("t4_release", IFID_Instr, 16'hC123);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t4_no_dup", IFID_Instr, 16'h1042);

        // HALT at 0x0010, then redirect to 0x0020.
        cyc(1, 1, 16'h0010, 0, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 1, 16'h0005);
        chk("t5_halted", {15'd0, halted}, 16'd1);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t5_no_req", {15'd0, imem_en}, 16'd0);
        cyc(0, 1, 16'h0020, 0, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t5_resume", IFID_PcPlusTwo, 16'h0022);

        // Flush with stall and same-cycle completion: the redirect wins.
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        cyc(1, 1, 16'h0030, 1, 1, 16'h1234);
        chk("t6_flush_wins", IFID_Instr, 16'h0800);
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        chk("t6_wait_addr", imem_addr, 16'h0030);

        // Reset asserted mid-WAIT.
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_done = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_en", {15'd0, imem_en}, 16'd0);
        chk_regs("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        chk("t6_after_rst", IFID_PcPlusTwo, 16'h0002);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        rs, rf, rd, ru;
            logic [15:0] rn, rdat;
            rs   = ($urandom_range(0, 3) == 0);
            rf   = ($urandom_range(0, 9) == 0);
            rd   = ($urandom_range(0, 1) == 1);
            ru   = ($urandom_range(0, 9) == 0);
            rn   = 16'($urandom);
            rdat = {5'b00000, 11'($urandom)};
            cyc(rs, rf, rn, rd, ru, rdat);
        end
        cyc(0, 0, 16'h0, 0, 0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
